// File: rtl/lc_trans_req_gate.sv
// lc_trans_req_gate: validates LC transition requests, issues them to the LC FSM and reports status
module lc_trans_req_gate #(
  parameter int               TOKEN_W        = 32,
  parameter logic [TOKEN_W-1:0] UNLOCK_TOKEN = 32'hC0DE_5EC1,
  parameter int               TIMEOUT_CYC    = 16,
  parameter int               MAX_TOKEN_FAIL = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_target,
  input  logic [TOKEN_W-1:0] req_token,
  input  logic [2:0]         cur_state,
  output logic               trans_cmd,
  output logic [2:0]         trans_target,
  input  logic               trans_done,
  input  logic               trans_success,
  input  logic               trans_invalid_error,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2:0]         rsp_status,
  output logic               busy
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int FW = $clog2(MAX_TOKEN_FAIL + 1);
  localparam logic [2:0] ST_OK = 3'd0, ST_ILLEGAL = 3'd1, ST_TOKEN = 3'd2,
                         ST_FSM = 3'd3, ST_TIMEOUT = 3'd4, ST_LOCKED = 3'd5;
  typedef enum logic [2:0] {IDLE, CHECK, CMD, WAIT, RESP, LOCKOUT} state_e;
  state_e             state_q;
  logic [2:0]         tgt_q;
  logic [TOKEN_W-1:0] tok_q;
  logic [TW-1:0]      tmo_q;
  logic [FW-1:0]      fail_q;
  logic               legal, gated, fail_max;
  // Legal-transition matrix; gated pairs additionally need the unlock token
  always_comb begin
    gated = (cur_state == 3'd2 && tgt_q == 3'd1) ||
            (cur_state == 3'd1 && tgt_q == 3'd3) ||
            (cur_state == 3'd2 && tgt_q == 3'd3);
    legal = gated || (cur_state == 3'd0 && tgt_q == 3'd1) ||
            (cur_state == 3'd1 && tgt_q == 3'd2);
    fail_max = fail_q == FW'(MAX_TOKEN_FAIL);
  end
  // Request/response FSM with registered handshake and command outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready    <= 1'b1;
      trans_cmd    <= 1'b0;
      trans_target <= '0;
      rsp_valid    <= 1'b0;
      rsp_status   <= ST_OK;
      busy         <= 1'b0;
      tgt_q        <= '0;
      tok_q        <= '0;
      tmo_q        <= '0;
      fail_q       <= '0;
    end else begin
      trans_cmd <= 1'b0;
      case (state_q)
        IDLE: if (req_valid) begin
          tgt_q     <= req_target;
          tok_q     <= req_token;
          req_ready <= 1'b0;
          busy      <= 1'b1;
          state_q   <= CHECK;
        end
        CHECK: if (!legal) begin
          rsp_status <= ST_ILLEGAL;
          rsp_valid  <= 1'b1;
          state_q    <= RESP;
        end else if (gated && tok_q != UNLOCK_TOKEN) begin
          rsp_status <= ST_TOKEN;
          rsp_valid  <= 1'b1;
          fail_q     <= fail_max ? fail_q : fail_q + 1'b1;
          state_q    <= RESP;
        end else begin
          trans_cmd    <= 1'b1;
          trans_target <= tgt_q;
          fail_q       <= gated ? '0 : fail_q;
          state_q      <= CMD;
        end
        CMD: begin
          tmo_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          tmo_q <= tmo_q + 1'b1;
          if (trans_done || tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            rsp_status <= !trans_done ? ST_TIMEOUT :
                          (trans_success && !trans_invalid_error) ? ST_OK : ST_FSM;
            rsp_valid  <= 1'b1;
            state_q    <= RESP;
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state_q   <= fail_max ? LOCKOUT : IDLE;
        end
        LOCKOUT: if (req_valid) begin
          rsp_status <= ST_LOCKED;
          rsp_valid  <= 1'b1;
          req_ready  <= 1'b0;
          busy       <= 1'b1;
          state_q    <= RESP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lc_trans_req_gate.sv
// tb_lc_trans_req_gate: directed table-driven bench for the LC transition request gate
module tb_lc_trans_req_gate;
  localparam logic [31:0] UT = 32'hC0DE_5EC1;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready;
  logic [2:0] req_target = 0, cur_state = 0, trans_target, rsp_status;
  logic [31:0] req_token = 0;
  logic trans_cmd, trans_done = 0, trans_success = 0, trans_invalid_error = 0;
  logic rsp_valid, rsp_ready = 0, busy;
  int checks = 0, errors = 0;

  lc_trans_req_gate dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_target(req_target), .req_token(req_token), .cur_state(cur_state),
    .trans_cmd(trans_cmd), .trans_target(trans_target), .trans_done(trans_done),
    .trans_success(trans_success), .trans_invalid_error(trans_invalid_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] cur, tgt; logic [31:0] tok; int dly; logic s, inv;
    int ecmd; logic [2:0] est; int ercyc;
  } vec_t;
  vec_t v[15];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_req(input logic [2:0] cur, tgt, input logic [31:0] tok, input int dly,
                        input logic s, inv, input int hold,
                        output int ncmd, output int cmd_cyc, output logic [2:0] cmd_tgt,
                        output logic [2:0] st, output int rcyc, output logic ok_hs);
    int c, seen;
    logic done;
    ncmd = 0; cmd_cyc = -1; cmd_tgt = 0; st = 0; rcyc = -1; ok_hs = 1; seen = 0; done = 0;
    cur_state = cur; req_target = tgt; req_token = tok; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0; c = 1;
    while (!done && c < 80) begin
      trans_done = 0; trans_success = 0; trans_invalid_error = 0; rsp_ready = 0;
      if (trans_cmd) begin ncmd++; cmd_cyc = c; cmd_tgt = trans_target; end
      if (cmd_cyc >= 0 && dly >= 0 && c == cmd_cyc + dly) begin
        trans_done = 1; trans_success = s; trans_invalid_error = inv;
      end
      if (rsp_valid) begin
        if (seen == 0) begin st = rsp_status; rcyc = c; end
        else if (rsp_status != st) ok_hs = 0;
        if (req_ready) ok_hs = 0;
        if (seen >= hold) begin rsp_ready = 1; done = 1; end
        seen++;
      end else if (seen > 0) ok_hs = 0;
      @(posedge clk); #1;
      c++;
    end
    trans_done = 0; trans_success = 0; trans_invalid_error = 0; rsp_ready = 0;
  endtask

  task automatic pulse_rst();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    int ncmd, cmd_cyc, rcyc, nrsp;
    logic [2:0] cmd_tgt, st;
    logic ok_hs;
    v[0]  = '{3'd0, 3'd1, 32'd0, 3,  1'b1, 1'b0, 1, 3'd0, 6};
    v[1]  = '{3'd0, 3'd3, 32'd0, -1, 1'b0, 1'b0, 0, 3'd1, 2};
    v[2]  = '{3'd2, 3'd3, UT,    2,  1'b1, 1'b0, 1, 3'd0, 5};
    v[3]  = '{3'd2, 3'd3, 32'd0, -1, 1'b0, 1'b0, 0, 3'd2, 2};
    v[4]  = '{3'd2, 3'd1, UT,    1,  1'b1, 1'b0, 1, 3'd0, 4};
    v[5]  = '{3'd1, 3'd2, 32'd0, -1, 1'b0, 1'b0, 1, 3'd4, 19};
    v[6]  = '{3'd1, 3'd2, 32'd0, 4,  1'b1, 1'b1, 1, 3'd3, 7};
    v[7]  = '{3'd1, 3'd2, 32'd0, 16, 1'b1, 1'b0, 1, 3'd0, 19};
    v[8]  = '{3'd1, 3'd2, 32'd0, 17, 1'b1, 1'b0, 1, 3'd4, 19};
    v[9]  = '{3'd3, 3'd1, UT,    -1, 1'b0, 1'b0, 0, 3'd1, 2};
    v[10] = '{3'd1, 3'd1, 32'd0, -1, 1'b0, 1'b0, 0, 3'd1, 2};
    v[11] = '{3'd0, 3'd5, 32'd0, -1, 1'b0, 1'b0, 0, 3'd1, 2};
    v[12] = '{3'd7, 3'd3, UT,    -1, 1'b0, 1'b0, 0, 3'd1, 2};
    v[13] = '{3'd2, 3'd2, UT,    -1, 1'b0, 1'b0, 0, 3'd1, 2};
    v[14] = '{3'd1, 3'd2, 32'd0, 2,  1'b0, 1'b0, 1, 3'd3, 5};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_trans_cmd", trans_cmd, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_status", rsp_status, 0);
    chk("rst_busy", busy, 0);
    rst = 0;

    for (int i = 0; i < 15; i++) begin
      do_req(v[i].cur, v[i].tgt, v[i].tok, v[i].dly, v[i].s, v[i].inv, 0,
             ncmd, cmd_cyc, cmd_tgt, st, rcyc, ok_hs);
      chk($sformatf("v%0d_ncmd", i), ncmd, v[i].ecmd);
      if (v[i].ecmd == 1) begin
        chk($sformatf("v%0d_cmd_cycle", i), cmd_cyc, 2);
        chk($sformatf("v%0d_cmd_target", i), cmd_tgt, v[i].tgt);
      end
      chk($sformatf("v%0d_status", i), st, v[i].est);
      chk($sformatf("v%0d_rsp_cycle", i), rcyc, v[i].ercyc);
      chk($sformatf("v%0d_hs", i), ok_hs, 1);
      chk($sformatf("v%0d_busy_after", i), busy, 0);
      chk($sformatf("v%0d_ready_after", i), req_ready, 1);
    end

    for (int i = 0; i < 3; i++) begin
      do_req(3'd1, 3'd3, 32'd0, -1, 0, 0, 0, ncmd, cmd_cyc, cmd_tgt, st, rcyc, ok_hs);
      chk($sformatf("lk%0d_status", i), st, 2);
      chk($sformatf("lk%0d_ncmd", i), ncmd, 0);
    end
    chk("lockout_ready", req_ready, 1);
    chk("lockout_busy", busy, 0);
    do_req(3'd1, 3'd2, 32'd0, 1, 1, 0, 0, ncmd, cmd_cyc, cmd_tgt, st, rcyc, ok_hs);
    chk("locked_status", st, 5);
    chk("locked_ncmd", ncmd, 0);
    chk("locked_rsp_cycle", rcyc, 1);
    do_req(3'd0, 3'd1, 32'd0, 1, 1, 0, 0, ncmd, cmd_cyc, cmd_tgt, st, rcyc, ok_hs);
    chk("locked2_status", st, 5);
    chk("locked2_ncmd", ncmd, 0);

    pulse_rst();
    do_req(3'd0, 3'd1, 32'd0, 3, 1, 0, 0, ncmd, cmd_cyc, cmd_tgt, st, rcyc, ok_hs);
    chk("unlock_ncmd", ncmd, 1);
    chk("unlock_status", st, 0);
    chk("unlock_rsp_cycle", rcyc, 6);

    do_req(3'd3, 3'd0, 32'd0, -1, 0, 0, 5, ncmd, cmd_cyc, cmd_tgt, st, rcyc, ok_hs);
    chk("hold_status", st, 1);
    chk("hold_stable", ok_hs, 1);
    chk("hold_rsp_cycle", rcyc, 2);

    cur_state = 3'd1; req_target = 3'd2; req_token = 0; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("midwait_busy", busy, 1);
    chk("midwait_target", trans_target, 2);
    pulse_rst();
    chk("abort_req_ready", req_ready, 1);
    chk("abort_trans_cmd", trans_cmd, 0);
    chk("abort_trans_target", trans_target, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_rsp_status", rsp_status, 0);
    chk("abort_busy", busy, 0);
    nrsp = 0; ncmd = 0;
    trans_done = 1; trans_success = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      trans_done = 0; trans_success = 0;
      if (rsp_valid) nrsp++;
      if (trans_cmd) ncmd++;
    end
    chk("abort_no_rsp", nrsp, 0);
    chk("abort_no_cmd", ncmd, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lc_trans_req_gate.md
Name: lc_trans_req_gate

Overview:
- Upstream front-end to the life-cycle controller transition FSM.
- Accepts transition requests (target state + unlock token) over a valid/ready interface and checks them against the current LC state and a fixed legal-transition matrix.
- Legal requests are issued to the LC FSM as a single-cycle trans_cmd/trans_target. The block then waits for the FSM result, with a timeout, and returns a status word over a response handshake.
- After repeated token failures the block locks out permanently until reset.

Parameters:
- TOKEN_W, 32, width of unlock token.
- UNLOCK_TOKEN, 32'hC0DE_5EC1, token required for token-gated transitions.
- TIMEOUT_CYC, 16, maximum cycles spent in WAIT before reporting timeout (≥2).
- MAX_TOKEN_FAIL, 3, consecutive token failures that trigger lockout (≥1).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_target  in  3  requested state: 0 Raw, 1 TestUnlocked0, 2 TestLocked0, 3 Rma, 7 Invalid
- req_token  in  TOKEN_W  unlock token
- cur_state  in  3  current decoded LC state from the FSM
- trans_cmd  out  1  one-cycle transition command to the LC FSM
- trans_target  out  3  target state, valid while trans_cmd=1
- trans_done  in  1  one-cycle pulse from the FSM: result available
- trans_success  in  1  FSM result, sampled with trans_done
- trans_invalid_error  in  1  FSM error, sampled with trans_done
- rsp_valid  out  1  response valid, held until rsp_ready
- rsp_ready  in  1  response consumer ready
- rsp_status  out  3  0 OK, 1 ILLEGAL, 2 TOKEN_ERR, 3 FSM_ERR, 4 TIMEOUT, 5 LOCKED
- busy  out  1  high in every state except IDLE and LOCKOUT

Behaviour:
- Interface:
  - One clock.
  - Reset is synchronous and active-high.
- Reset:
  - State = IDLE.
  - req_ready=1, trans_cmd=0, trans_target=0, rsp_valid=0, rsp_status=0, busy=0.
  - Token-fail counter = 0; timeout counter = 0.
  - Reset in any state, including mid-WAIT, aborts with no response and no further trans_cmd.
- States: IDLE, CHECK, CMD, WAIT, RESP, LOCKOUT.
- IDLE:
  - req_ready=1.
  - On handshake, capture req_target and req_token, then go to CHECK.
- CHECK (one cycle):
  - Sample cur_state and evaluate the request in this priority order:
    - (a) If the target/current pair is not in the legal matrix: status ILLEGAL.
    - (b) Else, if the pair is token-gated and the captured token != UNLOCK_TOKEN: status TOKEN_ERR, and the fail counter increments (saturating at MAX_TOKEN_FAIL).
    - (c) Else: go to CMD. If the pair is token-gated, the fail counter clears.
  - Failures go to RESP.
- Legal matrix:
  - Raw→TU0 (no token).
  - TU0→TL0 (no token).
  - TL0→TU0 (token).
  - TU0→Rma (token).
  - TL0→Rma (token).
  - All other pairs are ILLEGAL, including from Rma, from Invalid, self-transitions, and target codes 4–7.
- CMD (one cycle):
  - trans_cmd=1, trans_target=captured target.
  - Next state is WAIT, with the timeout counter cleared.
  - trans_cmd is never high in any other state.
- WAIT:
  - The timeout counter increments each cycle.
  - On trans_done: if trans_success=1 and trans_invalid_error=0, status OK; otherwise status FSM_ERR. Go to RESP.
  - If trans_done has not arrived by the end of cycle TIMEOUT_CYC in WAIT: status TIMEOUT, go to RESP.
  - If trans_done and the timeout coincide, trans_done wins.
- RESP:
  - rsp_valid=1; rsp_status is stable until rsp_ready is sampled high.
  - Exit: if the fail counter == MAX_TOKEN_FAIL, go to LOCKOUT; otherwise go to IDLE.
  - req_ready=0 throughout.
- LOCKOUT:
  - req_ready=1; every accepted request is answered with LOCKED via the RESP handshake and then returns to LOCKOUT.
  - trans_cmd is never asserted.
  - Exit only via rst.
- Latency (request accepted at cycle 0):
  - CHECK at cycle 1.
  - trans_cmd at cycle 2 when legal; rsp_valid at cycle 2 when rejected in CHECK.
  - For an accepted transition, rsp_valid asserts the cycle after trans_done is sampled.
- Other rules:
  - trans_done outside WAIT is ignored.
  - cur_state is used only in CHECK.
  - rsp_valid and req_ready are never both 1, except in LOCKOUT's idle phase, where rsp_valid=0.

Test Plan:
- Reset, cur_state=0, request target=1, token=0; FSM pulses trans_done+trans_success 3 cycles after trans_cmd → exactly one trans_cmd at cycle 2 with trans_target=1; rsp_status=0; busy low after the response handshake.
- cur_state=0, target=3 → rsp_status=1 at cycle 2; trans_cmd never asserted.
- cur_state=2, target=3, token=32'hC0DE_5EC1 → trans_cmd with target 3.
- Same case with token=0 → TOKEN_ERR.
- Three consecutive wrong-token requests (cur_state=1, target=3) → third response TOKEN_ERR, then LOCKOUT; next request (target=2) → LOCKED, no trans_cmd.
- Reset then clears the lockout, and a legal request succeeds.
- Legal request with no trans_done → rsp_status=4 after 16 WAIT cycles.
- Repeat with trans_done+trans_invalid_error → status 3.
- Repeat with trans_done on the final timeout cycle → status 0.
- Hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_status stable, req_ready=0.
- Assert rst during WAIT → all outputs at reset values next cycle, no response issued.
